axil_rd_reg_slice: RTL and testbench
====================================

# axil_rd_reg_slice

AXI-Lite read-path register slice, placed between one master and its `m_axil_*` read port on the read interconnect. It breaks every combinational path on the AR channel with a two-entry skid buffer, sustaining one transfer per cycle. Optionally it breaks the R channel the same way. No transaction is reordered, dropped, duplicated or modified.

## Interface
- `ADDR_W`, default `AXI_ADDR_WIDTH` (from `axil_pkg`): AR address width.
- `DATA_W`, default `AXI_DATA_WIDTH` (from `axil_pkg`): R data width.
- `aclk` in 1: the only clock; everything is rising-edge.
- `aresetn` in 1: synchronous, active-low reset.
- `m_axil_araddr` in `ADDR_W`: AR address from the master.
- `m_axil_arvalid` in 1: AR valid from the master.
- `m_axil_arready` out 1: AR ready to the master.
- `m_axil_rdata` out `DATA_W`: R data to the master.
- `m_axil_rresp` out 2: R response to the master.
- `m_axil_rvalid` out 1: R valid to the master.
- `m_axil_rready` in 1: R ready from the master.
- `s_axil_araddr` out `ADDR_W`: AR address to the interconnect master port.
- `s_axil_arvalid` out 1: AR valid to the interconnect.
- `s_axil_arready` in 1: AR ready from the interconnect.
- `s_axil_rdata` in `DATA_W`: R data from the interconnect.
- `s_axil_rresp` in 2: R response from the interconnect.
- `s_axil_rvalid` in 1: R valid from the interconnect.
- `s_axil_rready` out 1: R ready to the interconnect.

## Operation
- Each registered channel is one skid buffer instance with:
  - an output register `{out_valid, out_data}`;
  - a skid register `{skid_valid, skid_data}`.
- Input ready is registered: `in_ready_q <= !skid_valid_next`.
- Accept condition: `in_valid && in_ready_q`.
  - If `!out_valid || out_ready`: the accepted data loads the output register.
  - Otherwise: it loads the skid register.
- Drain condition: `out_valid && out_ready`.
  - If `skid_valid`: the skid register moves to the output register and the skid is cleared.
  - Otherwise: `out_valid` takes the value of the accept condition.
- Accept and drain in the same cycle with the skid empty: pass-through at full rate, and `in_ready` stays 1.
- The skid fills only when the output is stalled while the input presents data. The next cycle, `in_ready` drops to 0.
- Data fields are loaded only on accept. The valid bits alone carry state.
- States per channel:
  - EMPTY (`out_valid = 0`, `skid_valid = 0`)
  - ONE (`out_valid = 1`, `skid_valid = 0`)
  - FULL (`out_valid = 1`, `skid_valid = 1`)
- Transitions:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on drain without accept.
  - ONE -> FULL on accept without drain.
  - FULL -> ONE on drain; no accept is possible in FULL.
- AXI rules enforced:
  - Once asserted, an output valid and its data stay stable until the handshake.
  - No output valid depends combinationally on the corresponding ready.

## Timing
- Reset (`aresetn = 0` at a clock edge):
  - `out_valid` and `skid_valid` clear, so `s_axil_arvalid = 0` and `m_axil_rvalid = 0`.
  - `m_axil_arready = 0` and `s_axil_rready = 0`.
  - Data registers clear to 0.
- Ready rises on the first edge after reset release.
- Reset mid-transaction discards all buffered beats. The surrounding masters and slaves reset in the same domain.
- AR latency: master handshake in cycle N -> `s_axil_arvalid = 1` in cycle N+1.
- R latency: 1 cycle when `AXIL_RD_SLICE_R_EN` is defined, 0 otherwise.
- Throughput: 1 beat/cycle per channel with downstream ready held at 1.
- Capacity: 2 beats per channel; a third beat cannot be accepted until one drains.

## Configuration
- `AXIL_RD_SLICE_R_EN` defined:
  - The R channel gets its own skid buffer: registered `m_axil_rvalid`, `m_axil_rdata` and `m_axil_rresp`, and registered `s_axil_rready`.
  - Round-trip latency grows by 1 cycle.
- `AXIL_RD_SLICE_R_EN` undefined:
  - R is pure wires: `m_axil_r* = s_axil_r*` and `s_axil_rready = m_axil_rready`, with no R flops and no reset effect on R.
  - AR is always registered.

## Structure
- `axil_pkg` supplies `AXI_ADDR_WIDTH`, `AXI_DATA_WIDTH` and a new `typedef enum logic [1:0] {AXIL_OKAY, AXIL_EXOKAY, AXIL_SLVERR, AXIL_DECERR} axil_resp_t`.
- Sub-module `axil_skid_buf`:
  - parameter `WIDTH`;
  - ports `aclk`, `aresetn`, `in_data`/`in_valid`/`in_ready`, `out_data`/`out_valid`/`out_ready`.
- Instantiate it once for AR (`WIDTH = ADDR_W`).
- Under the macro, instantiate it once more for R (`WIDTH = DATA_W + 2`, `{rresp, rdata}`).

## Test plan
- Single read:
  - Stimulus: araddr `0x0000_1000` handshake in cycle 5.
  - Required: `s_axil_arvalid = 1` with `0x0000_1000` in cycle 6.
  - Required: R beat `0xDEAD_BEEF`/OKAY delivered to the master unchanged with `m_axil_rvalid = 1`, one cycle after `s_axil_rvalid` when the macro is on, same cycle when off.
- Streaming:
  - Stimulus: 16 back-to-back ARs `0x0`…`0x3C` with `s_axil_arready = 1`.
  - Required: `m_axil_arready` never drops; 16 consecutive `s_axil_arvalid` cycles in order.
- Backpressure:
  - Stimulus: `s_axil_arready = 0` while the master offers `0x10`, `0x14`, `0x18`.
  - Required: first two accepted, `m_axil_arready = 0` from the next cycle.
  - Required: after ready returns, `0x10`, `0x14`, `0x18` emerge in order with no loss; `s_axil_araddr` stable while stalled.
- R stall (macro on):
  - Stimulus: `m_axil_rready` low for 4 cycles while two R beats (`0x1`/SLVERR, `0x2`/DECERR) arrive.
  - Required: both are held, then delivered in order; `s_axil_rready = 0` while FULL.
- Reset mid-stream:
  - Stimulus: `aresetn` low one cycle while FULL.
  - Required: next cycle all valids = 0 and all readies = 0; nothing is replayed after release.
- Random:
  - Stimulus: 10k cycles of random valid/ready on both sides.
  - Required: the scoreboard sees an exact in-order match; valid never deasserts without a handshake.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: default bus widths and the read response encoding.
package axil_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_EXOKAY = 2'b01,
    AXIL_SLVERR = 2'b10,
    AXIL_DECERR = 2'b11
  } axil_resp_t;

endpackage : axil_pkg

// File: rtl/axil_skid_buf.sv
// Two-entry valid/ready skid buffer. Every output, including in_ready, comes
// straight from a flop, so no combinational path crosses the buffer.
// Occupancy lives in the two valid bits alone:
//   EMPTY = {out_valid, skid_valid} = 00, ONE = 10, FULL = 11.
module axil_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;

  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic             w_skid_valid_nxt;
  logic [WIDTH-1:0] w_skid_data_nxt;
  logic             w_accept;
  logic             w_drain;

  // in_ready is registered, so it is low exactly while the skid is occupied.
  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_out_valid && out_ready;

  // Next-state: skid refills the output first, otherwise accepted data goes to
  // the output if it is free this cycle, else into the skid.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (w_drain && r_skid_valid) begin
      // FULL -> ONE. in_ready is low in FULL, so no accept can coincide.
      w_out_data_nxt   = r_skid_data;
      w_skid_valid_nxt = 1'b0;
    end else if (w_accept && (!r_out_valid || out_ready)) begin
      // EMPTY -> ONE, or ONE -> ONE pass-through at full rate.
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = in_data;
    end else if (w_accept) begin
      // ONE -> FULL: output stalled while the input presents data.
      w_skid_valid_nxt = 1'b1;
      w_skid_data_nxt  = in_data;
    end else if (w_drain) begin
      // ONE -> EMPTY.
      w_out_valid_nxt = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      // NOTE: the data registers are reset too, so the outputs read 0 after reset rather than X.
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule : axil_skid_buf

// File: rtl/axil_rd_reg_slice.sv
// AXI-Lite read-path register slice. The AR channel always passes through a
// skid buffer. Define AXIL_RD_SLICE_R_EN to give the R channel its own skid
// buffer as well; without it R is plain wires with zero latency.
module axil_rd_reg_slice
  import axil_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH
) (
  input  logic              aclk,
  input  logic              aresetn,
  // Upstream master side
  input  logic [ADDR_W-1:0] m_axil_araddr,
  input  logic              m_axil_arvalid,
  output logic              m_axil_arready,
  output logic [DATA_W-1:0] m_axil_rdata,
  output logic [1:0]        m_axil_rresp,
  output logic              m_axil_rvalid,
  input  logic              m_axil_rready,
  // Downstream interconnect side
  output logic [ADDR_W-1:0] s_axil_araddr,
  output logic              s_axil_arvalid,
  input  logic              s_axil_arready,
  input  logic [DATA_W-1:0] s_axil_rdata,
  input  logic [1:0]        s_axil_rresp,
  input  logic              s_axil_rvalid,
  output logic              s_axil_rready
);

  // AR channel: always registered.
  axil_skid_buf #(
    .WIDTH (ADDR_W)
  ) u_ar_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   (m_axil_araddr),
    .in_valid  (m_axil_arvalid),
    .in_ready  (m_axil_arready),
    .out_data  (s_axil_araddr),
    .out_valid (s_axil_arvalid),
    .out_ready (s_axil_arready)
  );

`ifdef AXIL_RD_SLICE_R_EN
  // R channel: response and data travel together as one {rresp, rdata} beat.
  logic [DATA_W+1:0] w_r_out;

  axil_skid_buf #(
    .WIDTH (DATA_W + 2)
  ) u_r_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   ({s_axil_rresp, s_axil_rdata}),
    .in_valid  (s_axil_rvalid),
    .in_ready  (s_axil_rready),
    .out_data  (w_r_out),
    .out_valid (m_axil_rvalid),
    .out_ready (m_axil_rready)
  );

  assign m_axil_rresp = w_r_out[DATA_W+1:DATA_W];
  assign m_axil_rdata = w_r_out[DATA_W-1:0];
`else
  // R channel: straight wires, unaffected by reset.
  assign m_axil_rdata  = s_axil_rdata;
  assign m_axil_rresp  = s_axil_rresp;
  assign m_axil_rvalid = s_axil_rvalid;
  assign s_axil_rready = m_axil_rready;
`endif

endmodule : axil_rd_reg_slice

// File: tb/tb_axil_rd_reg_slice.sv
// Self-checking bench for axil_rd_reg_slice. Inputs change on the falling edge
// and outputs are sampled 1 time unit later. Works with AXIL_RD_SLICE_R_EN
// either defined or undefined.
module tb_axil_rd_reg_slice;
  import axil_pkg::*;

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] m_araddr;
  logic          m_arvalid;
  logic          m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rvalid;
  logic          m_rready;
  logic [AW-1:0] s_araddr;
  logic          s_arvalid;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  axil_rd_reg_slice dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .m_axil_araddr  (m_araddr),
    .m_axil_arvalid (m_arvalid),
    .m_axil_arready (m_arready),
    .m_axil_rdata   (m_rdata),
    .m_axil_rresp   (m_rresp),
    .m_axil_rvalid  (m_rvalid),
    .m_axil_rready  (m_rready),
    .s_axil_araddr  (s_araddr),
    .s_axil_arvalid (s_arvalid),
    .s_axil_arready (s_arready),
    .s_axil_rdata   (s_rdata),
    .s_axil_rresp   (s_rresp),
    .s_axil_rvalid  (s_rvalid),
    .s_axil_rready  (s_rready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m_arvalid = 1'b0;
    m_araddr  = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    m_rready  = 1'b0;
  endtask

  // Hold reset for two edges, release it, then check the post-reset state.
  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rst_m_arready", m_arready, 0);
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_s_araddr",  s_araddr,  0);
    check("rst_m_rvalid",  m_rvalid,  0);
    check("rst_s_rready",  s_rready,  0);
  endtask

  // One AR-channel cycle: inputs driven, outputs expected in the same cycle.
  typedef struct {
    logic          arvalid;
    logic [AW-1:0] araddr;
    logic          s_arready;
    logic          exp_arready;
    logic          exp_s_arvalid;
    logic [AW-1:0] exp_s_araddr;
  } vec_t;

  vec_t tbl [8];

  logic [AW-1:0]   ar_q [$];
  logic [DW+1:0]   r_q  [$];

  initial begin
    // Backpressure: stall downstream while 0x10, 0x14, 0x18 are offered.
    tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0};   // EMPTY, accept 0x10
    tbl[1] = '{1'b1, 32'h14, 1'b0, 1'b1, 1'b1, 32'h10};  // ONE, 0x14 into skid
    tbl[2] = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10};  // FULL, ready dropped
    tbl[3] = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10};  // still stalled, stable
    tbl[4] = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h10};  // drain 0x10
    tbl[5] = '{1'b1, 32'h18, 1'b1, 1'b1, 1'b1, 32'h14};  // drain 0x14, accept 0x18
    tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h18};  // drain 0x18
    tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h18};  // EMPTY again

    aresetn = 1'b0;
    idle_inputs();
    do_reset();

    // ---------------- table-driven backpressure ----------------
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      m_arvalid = tbl[i].arvalid;
      m_araddr  = tbl[i].araddr;
      s_arready = tbl[i].s_arready;
      #1;
      check($sformatf("tbl%0d_m_arready", i), m_arready, tbl[i].exp_arready);
      check($sformatf("tbl%0d_s_arvalid", i), s_arvalid, tbl[i].exp_s_arvalid);
      check($sformatf("tbl%0d_s_araddr",  i), s_araddr,  tbl[i].exp_s_araddr);
    end

    // ---------------- single read ----------------
    @(negedge aclk);
    m_arvalid = 1'b1; m_araddr = 32'h0000_1000; s_arready = 1'b1;
    #1;
    check("single_ar_hs", m_arready, 1);
    check("single_ar_not_yet", s_arvalid, 0);
    @(negedge aclk);
    m_arvalid = 1'b0;
    #1;
    check("single_s_arvalid", s_arvalid, 1);
    check("single_s_araddr", s_araddr, 32'h0000_1000);
    @(negedge aclk);
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = AXIL_OKAY; m_rready = 1'b1;
    #1;
`ifdef AXIL_RD_SLICE_R_EN
    check("single_s_rready", s_rready, 1);
    check("single_r_not_yet", m_rvalid, 0);
    @(negedge aclk);
    s_rvalid = 1'b0;
    #1;
    check("single_m_rvalid", m_rvalid, 1);
    check("single_m_rdata", m_rdata, 32'hDEAD_BEEF);
    check("single_m_rresp", m_rresp, AXIL_OKAY);
    @(negedge aclk);
    #1;
    check("single_r_done", m_rvalid, 0);
`else
    check("single_m_rvalid", m_rvalid, 1);
    check("single_m_rdata", m_rdata, 32'hDEAD_BEEF);
    check("single_m_rresp", m_rresp, AXIL_OKAY);
    check("single_s_rready", s_rready, 1);
    @(negedge aclk);
    s_rvalid = 1'b0;
    #1;
    check("single_r_done", m_rvalid, 0);
`endif

    // ---------------- streaming 16 ARs ----------------
    for (int i = 0; i <= 16; i++) begin
      @(negedge aclk);
      m_arvalid = (i < 16);
      m_araddr  = (i < 16) ? AW'(i * 4) : '0;
      s_arready = 1'b1;
      #1;
      if (i < 16) check($sformatf("stream%0d_m_arready", i), m_arready, 1);
      if (i > 0) begin
        check($sformatf("stream%0d_s_arvalid", i), s_arvalid, 1);
        check($sformatf("stream%0d_s_araddr", i), s_araddr, AW'((i - 1) * 4));
      end
    end

    // ---------------- R stall ----------------
`ifdef AXIL_RD_SLICE_R_EN
    @(negedge aclk);
    m_rready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1; s_rresp = AXIL_SLVERR;
    #1;
    check("rstall_s_rready_0", s_rready, 1);
    @(negedge aclk);
    s_rdata = 32'h2; s_rresp = AXIL_DECERR;
    #1;
    check("rstall_s_rready_1", s_rready, 1);
    check("rstall_hold_data_1", m_rdata, 32'h1);
    @(negedge aclk);
    s_rvalid = 1'b0;
    #1;
    check("rstall_full_s_rready", s_rready, 0);
    check("rstall_full_m_rvalid", m_rvalid, 1);
    @(negedge aclk);
    #1;
    check("rstall_full_s_rready_2", s_rready, 0);
    check("rstall_full_data", m_rdata, 32'h1);
    @(negedge aclk);
    m_rready = 1'b1;
    #1;
    check("rstall_beat1_valid", m_rvalid, 1);
    check("rstall_beat1_data", m_rdata, 32'h1);
    check("rstall_beat1_resp", m_rresp, AXIL_SLVERR);
    @(negedge aclk);
    #1;
    check("rstall_beat2_valid", m_rvalid, 1);
    check("rstall_beat2_data", m_rdata, 32'h2);
    check("rstall_beat2_resp", m_rresp, AXIL_DECERR);
    check("rstall_ready_back", s_rready, 1);
    @(negedge aclk);
    #1;
    check("rstall_empty", m_rvalid, 0);
`else
    @(negedge aclk);
    m_rready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1; s_rresp = AXIL_SLVERR;
    #1;
    check("rwire_m_rvalid", m_rvalid, 1);
    check("rwire_m_rdata", m_rdata, 32'h1);
    check("rwire_m_rresp", m_rresp, AXIL_SLVERR);
    check("rwire_s_rready", s_rready, 0);
    @(negedge aclk);
    s_rvalid = 1'b0;
`endif

    // ---------------- reset while FULL ----------------
    @(negedge aclk);
    m_arvalid = 1'b1; m_araddr = 32'h100; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hAAAA; s_rresp = AXIL_OKAY; m_rready = 1'b0;
    @(negedge aclk);
    m_araddr = 32'h104; s_rdata = 32'hBBBB;
    #1;
    check("rstfull_accept2", m_arready, 1);
    @(negedge aclk);
    m_arvalid = 1'b0; s_rvalid = 1'b0; aresetn = 1'b0;
    #1;
    check("rstfull_is_full", m_arready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rstfull_m_arready", m_arready, 0);
    check("rstfull_s_arvalid", s_arvalid, 0);
    check("rstfull_s_rready", s_rready, 0);
    check("rstfull_m_rvalid", m_rvalid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      s_arready = 1'b1; m_rready = 1'b1;
      #1;
      check($sformatf("noreplay%0d_s_arvalid", i), s_arvalid, 0);
      check($sformatf("noreplay%0d_m_rvalid", i), m_rvalid, 0);
      check($sformatf("noreplay%0d_m_arready", i), m_arready, 1);
    end

    // ---------------- random traffic vs. queue model ----------------
    begin
      logic          ar_hs_prev    = 1'b0;
      logic          ar_stall_prev = 1'b0;
      logic [AW-1:0] ar_prev_addr  = '0;
      logic          r_hs_prev     = 1'b0;
      logic          r_stall_prev  = 1'b0;
      logic [DW+1:0] r_prev_beat   = '0;
      logic [DW+1:0] exp_beat;
      ar_q.delete();
      r_q.delete();
      m_arvalid = 1'b0;
      s_rvalid  = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        @(negedge aclk);
        // Sources obey AXI: a raised valid holds until its handshake.
        if (!m_arvalid || ar_hs_prev) begin
          m_arvalid = ($urandom_range(0, 3) != 0);
          m_araddr  = $urandom;
        end
        if (!s_rvalid || r_hs_prev) begin
          s_rvalid = ($urandom_range(0, 3) != 0);
          s_rdata  = $urandom;
          s_rresp  = 2'($urandom_range(0, 3));
        end
        s_arready = ($urandom_range(0, 3) != 0);
        m_rready  = ($urandom_range(0, 3) != 0);
        #1;

        // AR: a 2-deep FIFO with one cycle of latency.
        check("rnd_ar_valid", s_arvalid, ar_q.size() != 0);
        check("rnd_ar_ready", m_arready, ar_q.size() < 2);
        if (ar_stall_prev) begin
          check("rnd_ar_hold_valid", s_arvalid, 1);
          check("rnd_ar_hold_addr", s_araddr, ar_prev_addr);
        end
        if (s_arvalid && s_arready && ar_q.size() != 0)
          check("rnd_ar_order", s_araddr, ar_q.pop_front());
        if (m_arvalid && m_arready) ar_q.push_back(m_araddr);
        ar_hs_prev    = m_arvalid && m_arready;
        ar_stall_prev = s_arvalid && !s_arready;
        ar_prev_addr  = s_araddr;

`ifdef AXIL_RD_SLICE_R_EN
        check("rnd_r_valid", m_rvalid, r_q.size() != 0);
        check("rnd_r_ready", s_rready, r_q.size() < 2);
        if (r_stall_prev) begin
          check("rnd_r_hold_valid", m_rvalid, 1);
          check("rnd_r_hold_beat", {m_rresp, m_rdata}, r_prev_beat);
        end
        if (m_rvalid && m_rready && r_q.size() != 0) begin
          exp_beat = r_q.pop_front();
          check("rnd_r_order", {m_rresp, m_rdata}, exp_beat);
        end
        if (s_rvalid && s_rready) r_q.push_back({s_rresp, s_rdata});
        r_hs_prev = s_rvalid && s_rready;
`else
        check("rnd_rwire_valid", m_rvalid, s_rvalid);
        check("rnd_rwire_beat", {m_rresp, m_rdata}, {s_rresp, s_rdata});
        check("rnd_rwire_ready", s_rready, m_rready);
        r_hs_prev = s_rvalid && m_rready;
`endif
        r_stall_prev = m_rvalid && !m_rready;
        r_prev_beat  = {m_rresp, m_rdata};
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on run time in case the stimulus ever stops advancing.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule : tb_axil_rd_reg_slice
